slc3_sequencer: RTL and testbench

SLC3_SEQUENCER -- requirements
Module: slc3_sequencer

---
 rtl/slc3_pkg.sv | 75 +++++++
 rtl/slc3_wait_ctr.sv | 25 ++
 rtl/slc3_sequencer.sv | 179 +++++++++++++++++
 tb/tb_slc3_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/slc3_pkg.sv
// Shared types and encodings for the SLC-3 control sequencer.
// Define SLC3_PAUSE_IR_EN to add the post-fetch IR display pause states.
package slc3_pkg;

  typedef enum logic [4:0] {
    S_HALTED, S_18, S_33, S_35, S_32,
    S_01, S_05, S_09, S_00, S_22, S_12,
    S_04, S_21, S_20, S_06, S_25, S_27,
    S_07, S_23, S_16, S_13_1, S_13_2
`ifdef SLC3_PAUSE_IR_EN
    , S_PAUSE_IR1, S_PAUSE_IR2
`endif
  } slc3_state_e;

  typedef struct packed {
    logic       ld_mar;
    logic       ld_mdr;
    logic       ld_ir;
    logic       ld_ben;
    logic       ld_cc;
    logic       ld_reg;
    logic       ld_pc;
    logic       ld_led;
    logic       gate_pc;
    logic       gate_mdr;
    logic       gate_alu;
    logic       gate_marmux;
    logic [1:0] pcmux;
    logic       drmux;
    logic       sr1mux;
    logic       sr2mux;
    logic       addr1mux;
    logic [1:0] addr2mux;
    logic [1:0] aluk;
  } slc3_ctrl_t;

  localparam logic [1:0] PCMUX_PC1   = 2'b00;
  localparam logic [1:0] PCMUX_BUS   = 2'b01;
  localparam logic [1:0] PCMUX_ADDER = 2'b10;

  localparam logic [1:0] ADDR2_ZERO  = 2'b00;
  localparam logic [1:0] ADDR2_OFF6  = 2'b01;
  localparam logic [1:0] ADDR2_OFF9  = 2'b10;
  localparam logic [1:0] ADDR2_OFF11 = 2'b11;

  localparam logic ADDR1_PC  = 1'b0;
  localparam logic ADDR1_SR1 = 1'b1;

  localparam logic [1:0] ALUK_ADD   = 2'b00;
  localparam logic [1:0] ALUK_AND   = 2'b01;
  localparam logic [1:0] ALUK_NOT   = 2'b10;
  localparam logic [1:0] ALUK_PASSA = 2'b11;

  localparam logic DRMUX_IR = 1'b0;
  localparam logic DRMUX_R7 = 1'b1;

  localparam logic SR1MUX_11_9 = 1'b0;
  localparam logic SR1MUX_8_6  = 1'b1;

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_PSE  = 4'b1101;

  // States that own the SRAM for MEM_WAIT cycles.
  function automatic logic is_access_state(slc3_state_e s);
    return (s == S_33) || (s == S_25) || (s == S_16);
  endfunction

endpackage

// File: rtl/slc3_wait_ctr.sv
// SRAM access timer: loaded with MEM_WAIT-1, counts down to zero.
module slc3_wait_ctr #(
  parameter int MEM_WAIT = 2
) (
  input  logic Clk,
  input  logic Reset,
  input  logic load,
  input  logic dec,
  output logic done
);

  logic [3:0] count_reg;

  always_ff @(posedge Clk) begin
    if (Reset)
      count_reg <= '0;
    else if (load)
      count_reg <= 4'(MEM_WAIT - 1);
    else if (dec && (count_reg != '0))
      count_reg <= count_reg - 4'd1;
  end

  assign done = (count_reg == '0);

endmodule

// File: rtl/slc3_sequencer.sv
// SLC-3 control FSM: fetch/decode/execute with MEM_WAIT-cycle SRAM accesses.
// Optional SLC3_PAUSE_IR_EN adds a Continue handshake after every fetch.
module slc3_sequencer
  import slc3_pkg::*;
#(
  parameter int MEM_WAIT = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       IR_11,
  input  logic       BEN,
  output slc3_ctrl_t Ctrl,
  output logic       Mem_OE,
  output logic       Mem_WE,
  output logic       Mem_CE,
  output logic       Mem_UB,
  output logic       Mem_LB,
  output logic       Halted_o,
  output logic       Illegal
);

  slc3_state_e state_reg, state_next;
  logic        ctr_load, ctr_dec, wait_done;

  always_ff @(posedge Clk) begin
    if (Reset)
      state_reg <= S_HALTED;
    else
      state_reg <= state_next;
  end

  // Reload only on entry so the count survives the whole access.
  assign ctr_load = is_access_state(state_next) && (state_next != state_reg);
  assign ctr_dec  = is_access_state(state_reg);

  slc3_wait_ctr #(.MEM_WAIT(MEM_WAIT)) u_wait_ctr (
    .Clk   (Clk),
    .Reset (Reset),
    .load  (ctr_load),
    .dec   (ctr_dec),
    .done  (wait_done)
  );

  always_comb begin
    state_next = state_reg;
    Ctrl       = '0;
    Mem_OE     = 1'b1;
    Mem_WE     = 1'b1;
    Illegal    = 1'b0;
    unique case (state_reg)
      S_HALTED: if (Run) state_next = S_18;
      S_18: begin
        Ctrl.gate_pc = 1'b1;
        Ctrl.ld_mar  = 1'b1;
        Ctrl.ld_pc   = 1'b1;
        Ctrl.pcmux   = PCMUX_PC1;
        state_next   = S_33;
      end
      S_33, S_25: begin
        Mem_OE = 1'b0;
        if (wait_done) begin
          Ctrl.ld_mdr = 1'b1;
          state_next  = (state_reg == S_33) ? S_35 : S_27;
        end
      end
      S_35: begin
        Ctrl.gate_mdr = 1'b1;
        Ctrl.ld_ir    = 1'b1;
`ifdef SLC3_PAUSE_IR_EN
        state_next    = S_PAUSE_IR1;
`else
        state_next    = S_32;
`endif
      end
`ifdef SLC3_PAUSE_IR_EN
      S_PAUSE_IR1: if (Continue) state_next = S_PAUSE_IR2;
      S_PAUSE_IR2: if (!Continue) state_next = S_32;
`endif
      S_32: begin
        Ctrl.ld_ben = 1'b1;
        case (Opcode)
          OP_ADD:  state_next = S_01;
          OP_AND:  state_next = S_05;
          OP_NOT:  state_next = S_09;
          OP_BR:   state_next = S_00;
          OP_JMP:  state_next = S_12;
          OP_JSR:  state_next = S_04;
          OP_LDR:  state_next = S_06;
          OP_STR:  state_next = S_07;
          OP_PSE:  state_next = S_13_1;
          default: begin
            Illegal    = 1'b1;
            state_next = S_18;
          end
        endcase
      end
      S_01, S_05, S_09: begin
        Ctrl.gate_alu = 1'b1;
        Ctrl.ld_reg   = 1'b1;
        Ctrl.ld_cc    = 1'b1;
        Ctrl.sr1mux   = SR1MUX_8_6;
        Ctrl.sr2mux   = IR_5;
        Ctrl.aluk     = (state_reg == S_01) ? ALUK_ADD :
                        (state_reg == S_05) ? ALUK_AND : ALUK_NOT;
        state_next    = S_18;
      end
      S_00: state_next = BEN ? S_22 : S_18;
      S_22: begin
        Ctrl.ld_pc    = 1'b1;
        Ctrl.pcmux    = PCMUX_ADDER;
        Ctrl.addr1mux = ADDR1_PC;
        Ctrl.addr2mux = ADDR2_OFF9;
        state_next    = S_18;
      end
      S_12, S_20: begin
        Ctrl.ld_pc    = 1'b1;
        Ctrl.pcmux    = PCMUX_ADDER;
        Ctrl.addr1mux = ADDR1_SR1;
        Ctrl.addr2mux = ADDR2_ZERO;
        Ctrl.sr1mux   = SR1MUX_8_6;
        state_next    = S_18;
      end
      S_04: begin
        Ctrl.gate_pc = 1'b1;
        Ctrl.drmux   = DRMUX_R7;
        Ctrl.ld_reg  = 1'b1;
        state_next   = IR_11 ? S_21 : S_20;
      end
      S_21: begin
        Ctrl.ld_pc    = 1'b1;
        Ctrl.pcmux    = PCMUX_ADDER;
        Ctrl.addr1mux = ADDR1_PC;
        Ctrl.addr2mux = ADDR2_OFF11;
        state_next    = S_18;
      end
      S_06, S_07: begin
        Ctrl.sr1mux      = SR1MUX_8_6;
        Ctrl.addr1mux    = ADDR1_SR1;
        Ctrl.addr2mux    = ADDR2_OFF6;
        Ctrl.gate_marmux = 1'b1;
        Ctrl.ld_mar      = 1'b1;
        state_next       = (state_reg == S_06) ? S_25 : S_23;
      end
      S_27: begin
        Ctrl.gate_mdr = 1'b1;
        Ctrl.ld_reg   = 1'b1;
        Ctrl.ld_cc    = 1'b1;
        state_next    = S_18;
      end
      S_23: begin
        Ctrl.sr1mux   = SR1MUX_11_9;
        Ctrl.aluk     = ALUK_PASSA;
        Ctrl.gate_alu = 1'b1;
        Ctrl.ld_mdr   = 1'b1;
        state_next    = S_16;
      end
      S_16: begin
        Mem_WE = 1'b0;
        if (wait_done) state_next = S_18;
      end
      S_13_1: begin
        Ctrl.ld_led = 1'b1;
        if (Continue) state_next = S_13_2;
      end
      S_13_2: if (!Continue) state_next = S_18;
      default: state_next = S_HALTED;
    endcase
  end

  assign Halted_o = (state_reg == S_HALTED);
  assign Mem_CE   = 1'b0;
  assign Mem_UB   = 1'b0;
  assign Mem_LB   = 1'b0;

endmodule

// File: tb/tb_slc3_sequencer.sv
// Bench for slc3_sequencer: MEM_WAIT=2 and MEM_WAIT=4 instances checked per cycle
// against an instruction-level model of the expected control/memory outputs.
module tb_slc3_sequencer;
  import slc3_pkg::*;

  logic       Clk = 1'b0, Reset = 1'b1, run2 = 1'b0, run4 = 1'b0, cont = 1'b0;
  logic       ir5 = 1'b0, ir11 = 1'b0, ben = 1'b0;
  logic [3:0] opcode = 4'b0;
  slc3_ctrl_t ctrl2, ctrl4, ctrl_obs;
  logic oe2, we2, ce2, ub2, lb2, h2, ill2;
  logic oe4, we4, ce4, ub4, lb4, h4, ill4;
  logic oe_obs, we_obs, h_obs, ill_obs;
  logic sel = 1'b0;
  logic [25:0] obs_vec;
  int checks = 0, failures = 0;

  always #5 Clk = ~Clk;

  slc3_sequencer #(.MEM_WAIT(2)) u_dut2 (
    .Clk(Clk), .Reset(Reset), .Run(run2), .Continue(cont), .Opcode(opcode),
    .IR_5(ir5), .IR_11(ir11), .BEN(ben), .Ctrl(ctrl2), .Mem_OE(oe2), .Mem_WE(we2),
    .Mem_CE(ce2), .Mem_UB(ub2), .Mem_LB(lb2), .Halted_o(h2), .Illegal(ill2));

  slc3_sequencer #(.MEM_WAIT(4)) u_dut4 (
    .Clk(Clk), .Reset(Reset), .Run(run4), .Continue(cont), .Opcode(opcode),
    .IR_5(ir5), .IR_11(ir11), .BEN(ben), .Ctrl(ctrl4), .Mem_OE(oe4), .Mem_WE(we4),
    .Mem_CE(ce4), .Mem_UB(ub4), .Mem_LB(lb4), .Halted_o(h4), .Illegal(ill4));

  assign ctrl_obs = sel ? ctrl4 : ctrl2;
  assign oe_obs   = sel ? oe4 : oe2;
  assign we_obs   = sel ? we4 : we2;
  assign h_obs    = sel ? h4 : h2;
  assign ill_obs  = sel ? ill4 : ill2;
  assign obs_vec  = {ctrl_obs, oe_obs, we_obs, ill_obs, h_obs};

  // One expected cycle: outputs, Continue to drive afterwards, and the instruction inputs.
  typedef struct {
    slc3_ctrl_t c;
    logic oe, we, ill, cont, first, ir5, ir11, ben;
    logic [3:0] op;
  } exp_t;

  exp_t exp_q[$];
  exp_t tmpl;

  function automatic logic [25:0] ev(exp_t e);
    return {e.c, e.oe, e.we, e.ill, 1'b0};
  endfunction

  task automatic m_push(slc3_ctrl_t c, logic oe, logic we, logic ill, logic cn);
    exp_t e;
    e = tmpl;
    e.c = c; e.oe = oe; e.we = we; e.ill = ill; e.cont = cn;
    exp_q.push_back(e);
    tmpl.first = 1'b0;
  endtask

  task automatic m_s18();
    slc3_ctrl_t c;
    c = '0; c.gate_pc = 1; c.ld_mar = 1; c.ld_pc = 1; c.pcmux = 2'b00;
    m_push(c, 1, 1, 0, 0);
  endtask

  task automatic m_read(int w);
    slc3_ctrl_t c;
    for (int i = 0; i < w; i++) begin
      c = '0; c.ld_mdr = (i == w - 1);
      m_push(c, 0, 1, 0, 0);
    end
  endtask

  // Continue must go high then low again; the hold lengths are random.
  task automatic m_hold(logic led);
    int a, b;
    slc3_ctrl_t c;
    a = $urandom_range(1, 3);
    b = $urandom_range(1, 3);
    c = '0; c.ld_led = led;
    for (int i = 0; i < a; i++) m_push(c, 1, 1, 0, (i == a - 1));
    for (int i = 0; i < b; i++) m_push('0, 1, 1, 0, (i != b - 1));
  endtask

  task automatic m_instr(int w, logic [3:0] op, logic i5, logic i11, logic bn);
    slc3_ctrl_t c;
    logic legal;
    tmpl = '{c: '0, op: op, ir5: i5, ir11: i11, ben: bn, first: 1'b1, default: 1'b0};
    m_s18();
    m_read(w);
    c = '0; c.gate_mdr = 1; c.ld_ir = 1; m_push(c, 1, 1, 0, 0);
`ifdef SLC3_PAUSE_IR_EN
    m_hold(1'b0);
`endif
    legal = op inside {4'b0001, 4'b0101, 4'b1001, 4'b0000, 4'b1100,
                       4'b0100, 4'b0110, 4'b0111, 4'b1101};
    c = '0; c.ld_ben = 1; m_push(c, 1, 1, !legal, 0);
    c = '0;
    case (op)
      4'b0001, 4'b0101, 4'b1001: begin
        c.gate_alu = 1; c.ld_reg = 1; c.ld_cc = 1; c.sr1mux = 1; c.sr2mux = i5;
        c.aluk = (op == 4'b0001) ? 2'b00 : (op == 4'b0101) ? 2'b01 : 2'b10;
        m_push(c, 1, 1, 0, 0);
      end
      4'b0000: begin
        m_push('0, 1, 1, 0, 0);
        if (bn) begin
          c.ld_pc = 1; c.pcmux = 2'b10; c.addr2mux = 2'b10;
          m_push(c, 1, 1, 0, 0);
        end
      end
      4'b1100: begin
        c.ld_pc = 1; c.pcmux = 2'b10; c.addr1mux = 1; c.sr1mux = 1;
        m_push(c, 1, 1, 0, 0);
      end
      4'b0100: begin
        c.gate_pc = 1; c.drmux = 1; c.ld_reg = 1;
        m_push(c, 1, 1, 0, 0);
        c = '0; c.ld_pc = 1; c.pcmux = 2'b10;
        if (i11) c.addr2mux = 2'b11;
        else begin c.addr1mux = 1; c.sr1mux = 1; end
        m_push(c, 1, 1, 0, 0);
      end
      4'b0110, 4'b0111: begin
        c.sr1mux = 1; c.addr1mux = 1; c.addr2mux = 2'b01; c.gate_marmux = 1; c.ld_mar = 1;
        m_push(c, 1, 1, 0, 0);
        if (op == 4'b0110) begin
          m_read(w);
          c = '0; c.gate_mdr = 1; c.ld_reg = 1; c.ld_cc = 1;
          m_push(c, 1, 1, 0, 0);
        end else begin
          c = '0; c.aluk = 2'b11; c.gate_alu = 1; c.ld_mdr = 1;
          m_push(c, 1, 1, 0, 0);
          for (int i = 0; i < w; i++) m_push('0, 1, 0, 0, 0);
        end
      end
      4'b1101: m_hold(1'b1);
      default: ;
    endcase
  endtask

  task automatic begin_run(logic s);
    sel = s; cont = 0;
    @(negedge Clk); Reset = 1;
    @(negedge Clk); Reset = 0;
    if (s) run4 = 1; else run2 = 1;
    @(negedge Clk); run2 = 0; run4 = 0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    Reset = 1; run2 = 0; run4 = 0;
    @(negedge Clk); @(negedge Clk);
    checks++;
    if ({h2, h4} !== 2'b11) begin failures++; $display("FAIL reset_halted got=%b exp=11", {h2, h4}); end
    checks++;
    if ({ctrl2, ctrl4} !== '0) begin failures++; $display("FAIL reset_ctrl got=%h/%h exp=0", ctrl2, ctrl4); end
    checks++;
    if ({oe2, we2, oe4, we4} !== 4'hf) begin failures++; $display("FAIL reset_mem got=%b exp=1111", {oe2, we2, oe4, we4}); end
    checks++;
    if ({ce2, ub2, lb2, ill2, ce4, ub4, lb4, ill4} !== 8'h00) begin
      failures++; $display("FAIL reset_const got=%b exp=00000000", {ce2, ub2, lb2, ill2, ce4, ub4, lb4, ill4});
    end
    Reset = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      checks++;
      if ({h2, h4, oe2, we2} !== 4'hf) begin failures++; $display("FAIL hold_halted cyc=%0d got=%b exp=1111", i, {h2, h4, oe2, we2}); end
    end
    $display("txn reset done");
  endtask

  task automatic test_add();
    begin_run(0);
    m_instr(2, 4'b0001, 1, 0, 0);
    m_instr(2, 4'b0101, 0, 0, 0);
    m_instr(2, 4'b1001, 1, 0, 0);
    m_s18();
    for (int i = 0; i < exp_q.size(); i++) begin
      opcode = exp_q[i].op; ir5 = exp_q[i].ir5; ir11 = exp_q[i].ir11; ben = exp_q[i].ben;
      if (exp_q[i].first) $display("txn alu W=2 op=%b ir5=%b", opcode, ir5);
      #1;
      checks++;
      if (obs_vec !== ev(exp_q[i])) begin failures++; $display("FAIL alu step=%0d got=%h exp=%h", i, obs_vec, ev(exp_q[i])); end
      cont = exp_q[i].cont;
      @(negedge Clk);
    end
  endtask

  task automatic test_str();
    int wlow;
    wlow = 0;
    begin_run(1);
    m_instr(4, 4'b0111, 0, 0, 0);
    m_s18();
    for (int i = 0; i < exp_q.size(); i++) begin
      opcode = exp_q[i].op; ir5 = exp_q[i].ir5; ir11 = exp_q[i].ir11; ben = exp_q[i].ben;
      if (exp_q[i].first) $display("txn str W=4 op=%b", opcode);
      #1;
      if (we_obs === 1'b0) wlow++;
      checks++;
      if (obs_vec !== ev(exp_q[i])) begin failures++; $display("FAIL str step=%0d got=%h exp=%h", i, obs_vec, ev(exp_q[i])); end
      cont = exp_q[i].cont;
      @(negedge Clk);
    end
    checks++;
    if (wlow != 4) begin failures++; $display("FAIL str_we_cycles got=%0d exp=4", wlow); end
  endtask

  task automatic test_br_jsr_ldr();
    begin_run(0);
    m_instr(2, 4'b0000, 0, 0, 0);
    m_instr(2, 4'b0000, 0, 0, 1);
    m_instr(2, 4'b1100, 0, 0, 0);
    m_instr(2, 4'b0100, 0, 1, 0);
    m_instr(2, 4'b0100, 0, 0, 0);
    m_instr(2, 4'b0110, 0, 0, 0);
    m_instr(2, 4'b1111, 0, 0, 0);
    m_instr(2, 4'b0001, 0, 0, 0);
    m_s18();
    for (int i = 0; i < exp_q.size(); i++) begin
      opcode = exp_q[i].op; ir5 = exp_q[i].ir5; ir11 = exp_q[i].ir11; ben = exp_q[i].ben;
      if (exp_q[i].first) $display("txn ctl W=2 op=%b ir11=%b ben=%b", opcode, ir11, ben);
      #1;
      checks++;
      if (obs_vec !== ev(exp_q[i])) begin failures++; $display("FAIL ctl step=%0d got=%h exp=%h", i, obs_vec, ev(exp_q[i])); end
      cont = exp_q[i].cont;
      @(negedge Clk);
    end
  endtask

  task automatic test_reset_mid();
    int wlow;
    logic hit;
    wlow = 0; hit = 0;
    begin_run(1);
    m_instr(4, 4'b0111, 0, 0, 0);
    for (int i = 0; i < exp_q.size() && !hit; i++) begin
      opcode = exp_q[i].op; ir5 = exp_q[i].ir5; ir11 = exp_q[i].ir11; ben = exp_q[i].ben;
      if (exp_q[i].first) $display("txn str_reset W=4 op=%b", opcode);
      #1;
      checks++;
      if (obs_vec !== ev(exp_q[i])) begin failures++; $display("FAIL rmid step=%0d got=%h exp=%h", i, obs_vec, ev(exp_q[i])); end
      cont = exp_q[i].cont;
      if (exp_q[i].we == 1'b0) wlow++;
      if (wlow == 2) begin hit = 1; Reset = 1; end
      @(negedge Clk);
    end
    checks++;
    if ({h4, we4, oe4, ill4, ctrl4} !== {4'b1110, 22'h0}) begin
      failures++; $display("FAIL rmid_halt got=%b%b%b%b ctrl=%h exp=1110 ctrl=0", h4, we4, oe4, ill4, ctrl4);
    end
    Reset = 0; run4 = 1;
    @(negedge Clk); run4 = 0;
    exp_q.delete(); m_s18();
    checks++;
    if (obs_vec !== ev(exp_q[0])) begin failures++; $display("FAIL rmid_restart got=%h exp=%h", obs_vec, ev(exp_q[0])); end
  endtask

  task automatic test_pause();
    begin_run(0);
    m_instr(2, 4'b1101, 0, 0, 0);
    m_instr(2, 4'b1101, 0, 0, 0);
    m_s18();
    for (int i = 0; i < exp_q.size(); i++) begin
      opcode = exp_q[i].op; ir5 = exp_q[i].ir5; ir11 = exp_q[i].ir11; ben = exp_q[i].ben;
      if (exp_q[i].first) $display("txn pause W=2 op=%b", opcode);
      #1;
      checks++;
      if (obs_vec !== ev(exp_q[i])) begin failures++; $display("FAIL pause step=%0d got=%h exp=%h", i, obs_vec, ev(exp_q[i])); end
      cont = exp_q[i].cont;
      @(negedge Clk);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      begin_run(r[0]);
      for (int n = 0; n < 10; n++)
        m_instr(r[0] ? 4 : 2, 4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom), 1'($urandom));
      m_s18();
      for (int i = 0; i < exp_q.size(); i++) begin
        opcode = exp_q[i].op; ir5 = exp_q[i].ir5; ir11 = exp_q[i].ir11; ben = exp_q[i].ben;
        if (exp_q[i].first) $display("txn rand W=%0d op=%b ir5=%b ir11=%b ben=%b", r[0] ? 4 : 2, opcode, ir5, ir11, ben);
        #1;
        checks++;
        if (obs_vec !== ev(exp_q[i])) begin failures++; $display("FAIL rand step=%0d got=%h exp=%h", i, obs_vec, ev(exp_q[i])); end
        cont = exp_q[i].cont;
        @(negedge Clk);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_str();
    test_br_jsr_ldr();
    test_reset_mid();
    test_pause();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
